tinypong: RTL and testbench
===========================

# tinypong

Single-player Pong game core for the TinyTapeout harness: generates 640×480@60 Hz VGA timing from a 25 MHz clock, moves a player paddle from two push-buttons, bounces a ball, and drives 1-bit-per-channel RGB plus HSYNC/VSYNC on the dedicated outputs. It is the chip top level; nothing sits above it but the harness pads.

## Interface
- No parameters; geometry constants come from the shared package.
- `clk` in 1: 25 MHz pixel clock; the only clock.
- `rst_n` in 1: reset, asynchronous, active-high (1 = reset asserted); name kept for the harness.
- `ena` in 1: harness enable; ignored.
- `ui_in` in 8: [0] up button, [1] down button (active-high, assumed synchronous); [7:2] unused.
- `uio_in` in 8: unused.
- `uo_out` out 8: [0] HSYNC, [1] VSYNC, [2] R, [3] G, [4] B, [7:5] = 0.
- `uio_out` out 8: constant 0. `uio_oe` out 8: constant 0.
- Internal named registers (probed by benches): `ball_x`, `ball_y`, `paddle_y` (10 bits each).

## Operation
- Counters: `h_cnt` 0..799, `v_cnt` 0..524; `v_cnt` advances when `h_cnt` wraps.
- Horizontal: visible 0–639, front porch 640–655, sync 656–751, back porch 752–799. Vertical: visible 0–479, front 480–489, sync 490–491, back 492–524.
- HSYNC low for `h_cnt` 656–751, else high; VSYNC low for `v_cnt` 490–491, else high (negative polarity).
- Frame tick: one-cycle pulse at `h_cnt`=0, `v_cnt`=480. Game state updates only on this tick.
- Paddle: x 16–23, height 64, top = `paddle_y`. Up only: `paddle_y` −4, saturate at 0. Down only: +4, saturate at 416. Both or neither: no change.
- Ball: 8×8, top-left (`ball_x`,`ball_y`), direction bits `dx`,`dy` (1 = +). Each tick, position ±2 per axis, using pre-tick state for all tests:
  - Top: `dy`=0 and `ball_y`≤2 → `dy`=1, `ball_y`=0 then moves +2.
  - Bottom: `dy`=1 and `ball_y`≥470 → `dy`=0.
  - Right: `dx`=1 and `ball_x`≥630 → `dx`=0.
  - Paddle hit: `dx`=0, `ball_x` in 22..26, `ball_y`+8 > `paddle_y`, `ball_y` < `paddle_y`+64 → `dx`=1.
  - Miss: `dx`=0 and `ball_x`≤2 without hit → ball to (316,236), `dx`=1, `dy`=1.
  - Simultaneous x/y bounce (corner) both apply the same tick.
- Pixel: in visible area, RGB = 111 where ball or paddle covers (`h_cnt`,`v_cnt`), else 000; outside visible area RGB = 000.

## Timing
- Reset values: `h_cnt`=0, `v_cnt`=0, HSYNC=1, VSYNC=1, RGB=000, `ball_x`=316, `ball_y`=236, `dx`=1, `dy`=1, `paddle_y`=208.
- Reset mid-frame returns every register above immediately (async), resuming at counter 0 on release.
- HSYNC/VSYNC/RGB are registered: each reflects the counters of the previous cycle (1-cycle latency, equal for all outputs).
- Positions change exactly once per 420 000 cycles (one frame); buttons sampled only at the tick.

## Structure
- Package `tinypong_pkg`: VGA timing constants (H/V visible, porch, sync, totals), paddle x/width/height/step, ball size/step, reset positions, screen limits.
- Sub-module `vga_timing`: counters, sync generation, visible flag, frame tick. Game logic and pixel mux stay in the top.

## Test plan
- Reset asserted then released → `uo_out`=0x03, ball (316,236), `paddle_y`=208; first HSYNC fall 657 cycles after release.
- Free-run → HSYNC period 800 cycles, low 96; VSYNC period 420 000 cycles, low 1600 cycles.
- Hold up 60 frames → `paddle_y` steps 208→204→…→0, stays 0; hold down → saturates at 416; both held → unchanged.
- No input, 2 frames after reset → ball (320,240), then (322,242); bottom bounce at `ball_y`=470 reverses `dy`.
- Paddle moved away from ball path → ball reaches `ball_x`≤2 with `dx`=0 → next tick (316,236), `dx`=`dy`=1.
- Pixel check: at `h_cnt`=320,`v_cnt`=240 after reset → RGB=111 one cycle later; at `h_cnt`=100 → RGB=000.

Source files
------------

// File: rtl/tinypong_pkg.sv
// tinypong_pkg: shared geometry for the tinypong core.
// Holds VGA 640x480@60 timing, paddle/ball sizes and steps, reset positions,
// screen limits, the output byte layout and a span-membership helper.
package tinypong_pkg;

  localparam int unsigned CNT_W = 10;

  typedef logic [CNT_W-1:0] coord_t;
  typedef logic [CNT_W:0]   wide_t;
  typedef logic [2:0]       rgb_t;

  // Dedicated output byte as seen by the harness pads.
  typedef struct packed {
    logic [2:0] zero;
    rgb_t       rgb;    // [0]=R, [1]=G, [2]=B
    logic       vsync;
    logic       hsync;
  } uo_t;

  // VGA timing (pixel clock 25 MHz)
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Paddle and ball geometry
  localparam int unsigned PADDLE_X     = 16;
  localparam int unsigned PADDLE_W     = 8;
  localparam int unsigned PADDLE_H     = 64;
  localparam int unsigned PADDLE_STEP  = 4;
  localparam int unsigned PADDLE_Y_RST = 208;
  localparam int unsigned BALL_SIZE    = 8;
  localparam int unsigned BALL_STEP    = 2;
  localparam int unsigned BALL_X_RST   = 316;
  localparam int unsigned BALL_Y_RST   = 236;
  localparam int unsigned BALL_EDGE    = 2;
  localparam int unsigned BALL_X_MAX   = 630;
  localparam int unsigned BALL_Y_MAX   = 470;
  localparam int unsigned HIT_X_MIN    = 22;
  localparam int unsigned HIT_X_MAX    = 26;

  // Counter-width copies used directly in comparisons
  localparam coord_t H_LAST_C       = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST_C       = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VISIBLE_C    = coord_t'(H_VISIBLE);
  localparam coord_t V_VISIBLE_C    = coord_t'(V_VISIBLE);
  localparam coord_t H_SYNC_LO_C    = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t H_SYNC_HI_C    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t V_SYNC_LO_C    = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t V_SYNC_HI_C    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam coord_t PADDLE_X_C     = coord_t'(PADDLE_X);
  localparam coord_t PADDLE_W_C     = coord_t'(PADDLE_W);
  localparam coord_t PADDLE_H_C     = coord_t'(PADDLE_H);
  localparam coord_t PADDLE_STEP_C  = coord_t'(PADDLE_STEP);
  localparam coord_t PADDLE_Y_MAX_C = coord_t'(V_VISIBLE - PADDLE_H);
  localparam coord_t PADDLE_Y_RST_C = coord_t'(PADDLE_Y_RST);
  localparam coord_t BALL_SIZE_C    = coord_t'(BALL_SIZE);
  localparam coord_t BALL_STEP_C    = coord_t'(BALL_STEP);
  localparam coord_t BALL_X_RST_C   = coord_t'(BALL_X_RST);
  localparam coord_t BALL_Y_RST_C   = coord_t'(BALL_Y_RST);
  localparam coord_t BALL_EDGE_C    = coord_t'(BALL_EDGE);
  localparam coord_t BALL_X_MAX_C   = coord_t'(BALL_X_MAX);
  localparam coord_t BALL_Y_MAX_C   = coord_t'(BALL_Y_MAX);
  localparam coord_t HIT_X_MIN_C    = coord_t'(HIT_X_MIN);
  localparam coord_t HIT_X_MAX_C    = coord_t'(HIT_X_MAX);

  // True when lo <= pos < lo+len; the sum is widened so it cannot wrap.
  function automatic logic in_span(input coord_t pos, input coord_t lo, input coord_t len);
    wide_t hi;
    hi = wide_t'(lo) + wide_t'(len);
    return (pos >= lo) && (wide_t'(pos) < hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 raster counters and decodes.
// Ports: clk, rst (async active-high); h_cnt/v_cnt registered counters;
// hsync_c/vsync_c (negative polarity), visible_c, frame_tick_c are
// combinational decodes of the current counters.
module vga_timing
  import tinypong_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hsync_c,
  output logic             vsync_c,
  output logic             visible_c,
  output logic             frame_tick_c
);

  coord_t h_cnt_q, h_cnt_d;
  coord_t v_cnt_q, v_cnt_d;

  // Horizontal counter wraps at 799; vertical advances on that wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + coord_t'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST_C) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt        = h_cnt_q;
  assign v_cnt        = v_cnt_q;
  assign hsync_c      = !((h_cnt_q >= H_SYNC_LO_C) && (h_cnt_q < H_SYNC_HI_C));
  assign vsync_c      = !((v_cnt_q >= V_SYNC_LO_C) && (v_cnt_q < V_SYNC_HI_C));
  assign visible_c    = (h_cnt_q < H_VISIBLE_C) && (v_cnt_q < V_VISIBLE_C);
  // First blanking line: game state advances here, never while drawing.
  assign frame_tick_c = (h_cnt_q == '0) && (v_cnt_q == V_VISIBLE_C);

endmodule

// File: rtl/tinypong.sv
// tinypong: single-player Pong chip top for the TinyTapeout harness.
// Ports: clk (25 MHz), rst_n (async, ACTIVE-HIGH despite the harness name),
// ena (ignored), ui_in[0]=up, ui_in[1]=down, uio_in (unused),
// uo_out = {000, B, G, R, VSYNC, HSYNC} registered, uio_out/uio_oe = 0.
module tinypong
  import tinypong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // The harness pin keeps its legacy name but 1 means reset.
  logic rst_c;
  assign rst_c = rst_n;

  logic unused_c;
  assign unused_c = &{1'b0, ena, uio_in, ui_in[7:2]};

  coord_t h_cnt, v_cnt;
  logic   hsync_c, vsync_c, visible_c, frame_tick_c;

  vga_timing u_timing (
    .clk          (clk),
    .rst          (rst_c),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .hsync_c      (hsync_c),
    .vsync_c      (vsync_c),
    .visible_c    (visible_c),
    .frame_tick_c (frame_tick_c)
  );

  coord_t ball_x, ball_x_d, ball_y, ball_y_d, paddle_y, paddle_y_d;
  logic   dx, dx_d, dy, dy_d;
  logic   hsync_q, hsync_d, vsync_q, vsync_d;
  rgb_t   rgb_q, rgb_d;
  logic   up_c, dn_c, hit_c, ball_px_c, paddle_px_c;

  assign up_c = ui_in[0];
  assign dn_c = ui_in[1];

  // Left-moving ball overlapping the paddle face; sums widened to avoid wrap.
  assign hit_c = !dx && (ball_x >= HIT_X_MIN_C) && (ball_x <= HIT_X_MAX_C) &&
                 (wide_t'(ball_y) + wide_t'(BALL_SIZE_C) > wide_t'(paddle_y)) &&
                 (wide_t'(ball_y) < wide_t'(paddle_y) + wide_t'(PADDLE_H_C));

  // Game state: every test uses pre-tick values; a miss overrides both axes.
  always_comb begin
    ball_x_d   = ball_x;
    ball_y_d   = ball_y;
    dx_d       = dx;
    dy_d       = dy;
    paddle_y_d = paddle_y;
    if (frame_tick_c) begin
      if (up_c && !dn_c) begin
        paddle_y_d = (paddle_y < PADDLE_STEP_C) ? '0 : paddle_y - PADDLE_STEP_C;
      end else if (dn_c && !up_c) begin
        paddle_y_d = (paddle_y >= PADDLE_Y_MAX_C - PADDLE_STEP_C) ? PADDLE_Y_MAX_C
                                                                  : paddle_y + PADDLE_STEP_C;
      end

      if (!dy && (ball_y <= BALL_EDGE_C)) begin
        dy_d     = 1'b1;
        ball_y_d = BALL_STEP_C;          // clamp to 0, then move down one step
      end else if (dy && (ball_y >= BALL_Y_MAX_C)) begin
        dy_d     = 1'b0;
        ball_y_d = ball_y - BALL_STEP_C;
      end else begin
        ball_y_d = dy ? ball_y + BALL_STEP_C : ball_y - BALL_STEP_C;
      end

      if (dx && (ball_x >= BALL_X_MAX_C)) begin
        dx_d     = 1'b0;
        ball_x_d = ball_x - BALL_STEP_C;
      end else if (hit_c) begin
        dx_d     = 1'b1;
        ball_x_d = ball_x + BALL_STEP_C;
      end else if (!dx && (ball_x <= BALL_EDGE_C)) begin
        ball_x_d = BALL_X_RST_C;
        ball_y_d = BALL_Y_RST_C;
        dx_d     = 1'b1;
        dy_d     = 1'b1;
      end else begin
        ball_x_d = dx ? ball_x + BALL_STEP_C : ball_x - BALL_STEP_C;
      end
    end
  end

  // Pixel mux and sync pipeline share one register stage.
  assign ball_px_c   = in_span(h_cnt, ball_x, BALL_SIZE_C) && in_span(v_cnt, ball_y, BALL_SIZE_C);
  assign paddle_px_c = in_span(h_cnt, PADDLE_X_C, PADDLE_W_C) && in_span(v_cnt, paddle_y, PADDLE_H_C);

  always_comb begin
    hsync_d = hsync_c;
    vsync_d = vsync_c;
    rgb_d   = (visible_c && (ball_px_c || paddle_px_c)) ? 3'b111 : 3'b000;
  end

  always_ff @(posedge clk or posedge rst_c) begin
    if (rst_c) begin
      ball_x   <= BALL_X_RST_C;
      ball_y   <= BALL_Y_RST_C;
      dx       <= 1'b1;
      dy       <= 1'b1;
      paddle_y <= PADDLE_Y_RST_C;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      rgb_q    <= '0;
    end else begin
      ball_x   <= ball_x_d;
      ball_y   <= ball_y_d;
      dx       <= dx_d;
      dy       <= dy_d;
      paddle_y <= paddle_y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      rgb_q    <= rgb_d;
    end
  end

  assign uo_out  = uo_t'{zero: 3'b000, rgb: rgb_q, vsync: vsync_q, hsync: hsync_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tinypong.sv
// tb_tinypong: scoreboard bench for tinypong. Frame ticks are reached by
// forcing the raster counters just ahead of the tick line; expected game
// states are queued at stimulus time and a monitor compares them on each tick.
module tb_tinypong;

  logic       clk, rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

  tinypong dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct { int bx; int by; int py; } exp_t;
  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_ticks = 0;

  int   m_bx, m_by, m_py;
  logic m_dx, m_dy;
  logic [9:0] f_h, f_v, f_bx, f_by, f_py;
  logic       f_dx, f_dy;

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_bx = 316; m_by = 236; m_py = 208; m_dx = 1'b1; m_dy = 1'b1;
  endfunction

  // Game rules from the pre-tick state.
  function automatic void model_tick(input logic up, input logic dn);
    bit   hit;
    int   nbx, nby;
    logic ndx, ndy;
    hit = !m_dx && m_bx >= 22 && m_bx <= 26 && (m_by + 8 > m_py) && (m_by < m_py + 64);
    ndx = m_dx;
    ndy = m_dy;
    if (!m_dy && m_by <= 2) begin
      ndy = 1'b1;
      nby = 2;
    end else begin
      if (m_dy && m_by >= 470) ndy = 1'b0;
      nby = ndy ? m_by + 2 : m_by - 2;
    end
    if (m_dx && m_bx >= 630) ndx = 1'b0;
    else if (hit)            ndx = 1'b1;
    nbx = ndx ? m_bx + 2 : m_bx - 2;
    if (!m_dx && m_bx <= 2 && !hit) begin
      nbx = 316; nby = 236; ndx = 1'b1; ndy = 1'b1;
    end
    if (up && !dn)      m_py = (m_py < 4) ? 0 : m_py - 4;
    else if (dn && !up) m_py = (m_py + 4 > 416) ? 416 : m_py + 4;
    m_bx = nbx; m_by = nby; m_dx = ndx; m_dy = ndy;
  endfunction

  // Park the raster two cycles before the tick, queue the expectation.
  task automatic run_tick(input logic up, input logic dn, input exp_t e);
    @(negedge clk);
    ui_in = {6'b0, dn, up};
    sb_q.push_back(e);
    f_h = 10'd799;
    f_v = 10'd479;
    force dut.u_timing.h_cnt_q = f_h;
    force dut.u_timing.v_cnt_q = f_v;
    #1;
    release dut.u_timing.h_cnt_q;
    release dut.u_timing.v_cnt_q;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ui_in = 8'h00;
  endtask

  task automatic frame_model(input logic up, input logic dn);
    exp_t e;
    model_tick(up, dn);
    e = '{m_bx, m_by, m_py};
    run_tick(up, dn, e);
  endtask

  task automatic frame_hand(input logic up, input logic dn, input int bx, input int by, input int py);
    exp_t e;
    model_tick(up, dn);
    e = '{bx, by, py};
    run_tick(up, dn, e);
  endtask

  task automatic set_state(input int bx, input int by, input logic dxv, input logic dyv, input int py);
    @(negedge clk);
    f_bx = 10'(bx); f_by = 10'(by); f_py = 10'(py); f_dx = dxv; f_dy = dyv;
    force dut.ball_x   = f_bx;
    force dut.ball_y   = f_by;
    force dut.paddle_y = f_py;
    force dut.dx       = f_dx;
    force dut.dy       = f_dy;
    #1;
    release dut.ball_x;
    release dut.ball_y;
    release dut.paddle_y;
    release dut.dx;
    release dut.dy;
    m_bx = bx; m_by = by; m_py = py; m_dx = dxv; m_dy = dyv;
  endtask

  task automatic pix_check(input int h, input int v, input logic [7:0] exp);
    @(negedge clk);
    f_h = 10'(h);
    f_v = 10'(v);
    force dut.u_timing.h_cnt_q = f_h;
    force dut.u_timing.v_cnt_q = f_v;
    #1;
    release dut.u_timing.h_cnt_q;
    release dut.u_timing.v_cnt_q;
    @(posedge clk);
    #1;
    check($sformatf("pixel_h%0d_v%0d", h, v), uo_out, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ui_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
  endtask

  // Monitor: one queued expectation per game tick.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n && dut.frame_tick_c === 1'b1) begin
        @(posedge clk);
        #1;
        n_ticks++;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tick%0d_unexpected: got ball=(%0d,%0d) paddle=%0d with nothing expected",
                   n_ticks, dut.ball_x, dut.ball_y, dut.paddle_y);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("tick%0d_ball_x", n_ticks), 32'(dut.ball_x), e.bx);
          check($sformatf("tick%0d_ball_y", n_ticks), 32'(dut.ball_y), e.by);
          check($sformatf("tick%0d_paddle_y", n_ticks), 32'(dut.paddle_y), e.py);
        end
      end
    end
  end

  initial begin : stim
    int cnt, per, lowc;
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    f_h = '0; f_v = '0; f_bx = '0; f_by = '0; f_py = '0; f_dx = 1'b0; f_dy = 1'b0;
    model_reset();

    // Reset values and first HSYNC edge
    repeat (3) @(negedge clk);
    check("rst_uo_out", uo_out, 8'h03);
    check("rst_ball_x", 32'(dut.ball_x), 316);
    check("rst_ball_y", 32'(dut.ball_y), 236);
    check("rst_paddle_y", 32'(dut.paddle_y), 208);
    check("uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h00);
    rst_n = 1'b0;
    cnt = 0;
    while (cnt < 2000) begin
      @(posedge clk); #1; cnt++;
      if (uo_out[0] == 1'b0) break;
    end
    check("hsync_first_fall", cnt, 657);
    per = 0; lowc = 0;
    while (per < 2000) begin
      @(posedge clk); #1; per++;
      if (uo_out[0] && lowc == 0) lowc = per;
      if (!uo_out[0] && lowc != 0) break;
    end
    check("hsync_low_cycles", lowc, 96);
    check("hsync_period", per, 800);

    // VSYNC pulse from line 489
    @(negedge clk);
    f_h = 10'd799; f_v = 10'd489;
    force dut.u_timing.h_cnt_q = f_h;
    force dut.u_timing.v_cnt_q = f_v;
    #1;
    release dut.u_timing.h_cnt_q;
    release dut.u_timing.v_cnt_q;
    cnt = 0;
    while (cnt < 10) begin
      @(posedge clk); #1; cnt++;
      if (!uo_out[1]) break;
    end
    check("vsync_fall_latency", cnt, 2);
    lowc = 0;
    while (lowc < 5000) begin
      @(posedge clk); #1; lowc++;
      if (uo_out[1]) break;
    end
    check("vsync_low_cycles", lowc, 1600);

    // Pixels around reset ball (316..323,236..243) and paddle (16..23,208..271)
    do_reset();
    pix_check(320, 240, 8'h1F);
    pix_check(100, 240, 8'h03);
    pix_check(315, 240, 8'h03);
    pix_check(316, 236, 8'h1F);
    pix_check(323, 243, 8'h1F);
    pix_check(324, 240, 8'h03);
    pix_check(320, 244, 8'h03);
    pix_check(16, 208, 8'h1F);
    pix_check(23, 271, 8'h1F);
    pix_check(24, 208, 8'h03);
    pix_check(20, 272, 8'h03);
    pix_check(15, 230, 8'h03);
    pix_check(650, 240, 8'h03);
    pix_check(700, 240, 8'h02);

    // Free ball motion, bottom bounce
    frame_hand(0, 0, 318, 238, 208);
    frame_hand(0, 0, 320, 240, 208);
    frame_hand(0, 0, 322, 242, 208);
    for (int i = 4; i <= 118; i++) frame_model(0, 0);
    check("bottom_bounce_ball_y", 32'(dut.ball_y), 468);
    check("bottom_bounce_ball_x", 32'(dut.ball_x), 552);

    // Paddle saturation both ways, both buttons held
    for (int i = 0; i < 60; i++) frame_model(1, 0);
    check("paddle_top_sat", 32'(dut.paddle_y), 0);
    for (int i = 0; i < 110; i++) frame_model(0, 1);
    check("paddle_bottom_sat", 32'(dut.paddle_y), 416);
    for (int i = 0; i < 3; i++) frame_model(1, 1);
    check("paddle_both_held", 32'(dut.paddle_y), 416);

    // Directed edge cases
    set_state(24, 40, 1'b0, 1'b1, 0);
    frame_hand(0, 0, 26, 42, 0);
    frame_hand(0, 0, 28, 44, 0);
    set_state(4, 100, 1'b0, 1'b1, 0);
    frame_hand(0, 0, 2, 102, 0);
    frame_hand(0, 0, 316, 236, 0);
    frame_hand(0, 0, 318, 238, 0);
    set_state(26, 64, 1'b0, 1'b0, 0);
    frame_hand(0, 0, 24, 62, 0);
    frame_hand(0, 0, 26, 60, 0);
    frame_hand(0, 0, 28, 58, 0);
    set_state(22, 92, 1'b0, 1'b1, 100);
    frame_hand(0, 0, 20, 94, 100);
    set_state(22, 93, 1'b0, 1'b1, 100);
    frame_hand(0, 0, 24, 95, 100);
    set_state(630, 470, 1'b1, 1'b1, 200);
    frame_hand(0, 0, 628, 468, 200);
    frame_hand(0, 0, 626, 466, 200);
    set_state(628, 300, 1'b1, 1'b1, 200);
    frame_hand(0, 0, 630, 302, 200);
    frame_hand(0, 0, 628, 304, 200);
    set_state(100, 1, 1'b1, 1'b0, 200);
    frame_hand(0, 0, 102, 2, 200);
    frame_hand(0, 0, 104, 4, 200);
    set_state(300, 300, 1'b1, 1'b1, 2);
    frame_hand(1, 0, 302, 302, 0);
    set_state(300, 300, 1'b1, 1'b1, 414);
    frame_hand(0, 1, 302, 302, 416);

    // Asynchronous reset mid-frame
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("async_rst_uo_out", uo_out, 8'h03);
    check("async_rst_ball_x", 32'(dut.ball_x), 316);
    check("async_rst_ball_y", 32'(dut.ball_y), 236);
    check("async_rst_paddle_y", 32'(dut.paddle_y), 208);
    check("async_rst_h_cnt", 32'(dut.u_timing.h_cnt_q), 0);
    check("async_rst_v_cnt", 32'(dut.u_timing.v_cnt_q), 0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    frame_hand(0, 0, 318, 238, 208);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
